// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// One action per edge: branch redirect, jump redirect, hold, memory wait, or fetch.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] IM_Addr,
    input  logic [31:0] IM_Data,
    input  logic        IM_Ready,
    input  logic        Stall,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IF_Order,
    output logic [31:0] IF_PC4,
    output logic        IF_Valid,
    output logic [31:0] PC
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pcReg;
    logic [31:0] pcPlus4;
    logic [31:0] orderReg;
    logic [31:0] pc4Reg;
    logic        validReg;

    // Targets are forced word aligned, so their low bits never reach the PC.
    logic unusedLowBits;
    assign unusedLowBits = ^{BranchTarget[1:0], JumpTarget[1:0]};

    assign pcPlus4 = pcReg + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcReg    <= RESET_PC_ALIGNED;
            orderReg <= NOP_WORD;
            pc4Reg   <= 32'd0;
            validReg <= 1'b0;
        end else if (BranchTaken) begin
            // The branch is older than the jump in ID, so it wins.
            pcReg    <= {BranchTarget[31:2], 2'b00};
            orderReg <= NOP_WORD;
            pc4Reg   <= 32'd0;
            validReg <= 1'b0;
        end else if (Jump) begin
            pcReg    <= {JumpTarget[31:2], 2'b00};
            orderReg <= NOP_WORD;
            pc4Reg   <= 32'd0;
            validReg <= 1'b0;
        end else if (Stall) begin
            pcReg    <= pcReg;
            orderReg <= orderReg;
            pc4Reg   <= pc4Reg;
            validReg <= validReg;
        end else if (!IM_Ready) begin
            orderReg <= NOP_WORD;
            pc4Reg   <= 32'd0;
            validReg <= 1'b0;
        end else begin
            pcReg    <= pcPlus4;
            orderReg <= IM_Data;
            pc4Reg   <= pcPlus4;
            validReg <= 1'b1;
        end
    end

    assign PC       = pcReg;
    assign IM_Addr  = pcReg;
    assign IF_Order = orderReg;
    assign IF_PC4   = pc4Reg;
    assign IF_Valid = validReg;

endmodule
